// File: rtl/cmd_sequencer_pkg.sv
// Shared types and constants for the command sequencer.
// Holds the FSM encoding, command word layout and ALU op codes.
package cmd_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        ISSUE,
        WAIT_ANS,
        CAPTURE,
        FINISH
    } state_e;

    localparam int CMD_W   = 20;
    localparam int S_MSB   = 19;
    localparam int S_LSB   = 17;
    localparam int CIN_BIT = 16;
    localparam int X_MSB   = 15;
    localparam int Y_MSB   = 7;

    typedef enum logic [2:0] {
        OP_CLR = 3'b000,
        OP_AND = 3'b001,
        OP_OR  = 3'b010,
        OP_XOR = 3'b011,
        OP_ADD = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_ROR = 3'b111
    } alu_op_e;

    // Cycles counted from entering ISSUE.
    localparam int ALU_LAT = 1;
    localparam int EXC_LAT = 2;

endpackage

// File: rtl/cmd_sequencer_if.sv
// ROM, ALU and result-record signals between the sequencer and its peers.
// master = sequencer side, slave = ROM/ALU/consumer side.
interface cmd_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] rom_addr;
    logic [19:0]       rom_data;
    logic [2:0]        alu_s;
    logic [7:0]        alu_x;
    logic [7:0]        alu_y;
    logic              alu_cin;
    logic [15:0]       alu_ans;
    logic              alu_exceed;
    logic              res_valid;
    logic [15:0]       res_ans;
    logic              res_exceed;
    logic [ADDR_W:0]   res_idx;

    modport master (
        output rom_addr,
        input  rom_data,
        output alu_s,
        output alu_x,
        output alu_y,
        output alu_cin,
        input  alu_ans,
        input  alu_exceed,
        output res_valid,
        output res_ans,
        output res_exceed,
        output res_idx
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  alu_s,
        input  alu_x,
        input  alu_y,
        input  alu_cin,
        output alu_ans,
        output alu_exceed,
        input  res_valid,
        input  res_ans,
        input  res_exceed,
        input  res_idx
    );
endinterface

// File: rtl/cmd_sequencer_decode.sv
// Combinational unpacking of a 20-bit command word into S/cin/X/Y.
module cmd_decode
    import cmd_sequencer_pkg::*;
(
    input  logic [CMD_W-1:0] word_i,
    output logic [2:0]       s_o,
    output logic             cin_o,
    output logic [7:0]       x_o,
    output logic [7:0]       y_o
);

    assign s_o   = word_i[S_MSB:S_LSB];
    assign cin_o = word_i[CIN_BIT];
    assign x_o   = word_i[X_MSB -: 8];
    assign y_o   = word_i[Y_MSB -: 8];

endmodule

// File: rtl/cmd_sequencer.sv
// Fetches commands from a synchronous ROM, issues them to the ALU and
// publishes one result record per command.
module cmd_sequencer
    import cmd_sequencer_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter bit STOP_ON_EXC = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   num_cmds,
    cmd_sequencer_if.master   bus,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] ISSUE_CYC = 2'(ALU_LAT - 1);
    localparam logic [1:0] WAIT_CYC  = 2'(EXC_LAT - ALU_LAT - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W:0]   res_idx_q;
    logic [1:0]        lat_q;
    logic [2:0]        s_q;
    logic              cin_q;
    logic [7:0]        x_q, y_q;
    logic [15:0]       ans_q;
    logic              exc_q;
    logic              vld_q;
    logic              busy_q;
    logic              done_q;
    logic              stop;

    logic [2:0] dec_s;
    logic       dec_cin;
    logic [7:0] dec_x, dec_y;

    cmd_decode u_decode (
        .word_i (bus.rom_data),
        .s_o    (dec_s),
        .cin_o  (dec_cin),
        .x_o    (dec_x),
        .y_o    (dec_y)
    );

    always_comb begin
        ptr_d = ptr_q + 1'b1;
        rem_d = rem_q - 1'b1;
        idx_d = idx_q + 1'b1;
        stop  = (rem_d == '0) || (STOP_ON_EXC && bus.alu_exceed);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            rom_addr_q <= '0;
            rem_q      <= '0;
            idx_q      <= '0;
            res_idx_q  <= '0;
            lat_q      <= '0;
            s_q        <= OP_CLR;
            cin_q      <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            ans_q      <= '0;
            exc_q      <= 1'b0;
            vld_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            vld_q  <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        ptr_q <= start_addr;
                        rem_q <= num_cmds;
                        idx_q <= '0;
                        if (num_cmds == '0) begin
                            state_q <= FINISH;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= FETCH;
                            busy_q     <= 1'b1;
                            rom_addr_q <= start_addr;
                        end
                    end
                end
                FETCH: begin
                    state_q <= LATCH;
                end
                LATCH: begin
                    s_q     <= dec_s;
                    cin_q   <= dec_cin;
                    x_q     <= dec_x;
                    y_q     <= dec_y;
                    lat_q   <= ISSUE_CYC;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    if (lat_q == '0) begin
                        lat_q   <= WAIT_CYC;
                        state_q <= WAIT_ANS;
                    end else begin
                        lat_q <= lat_q - 2'd1;
                    end
                end
                WAIT_ANS: begin
                    if (lat_q == '0) begin
                        state_q <= CAPTURE;
                    end else begin
                        lat_q <= lat_q - 2'd1;
                    end
                end
                CAPTURE: begin
                    ans_q     <= bus.alu_ans;
                    exc_q     <= bus.alu_exceed;
                    res_idx_q <= idx_q;
                    vld_q     <= 1'b1;
                    ptr_q     <= ptr_d;
                    idx_q     <= idx_d;
                    rem_q     <= rem_d;
                    if (stop) begin
                        state_q <= FINISH;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= FETCH;
                        rom_addr_q <= ptr_d;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.rom_addr   = rom_addr_q;
    assign bus.alu_s      = s_q;
    assign bus.alu_cin    = cin_q;
    assign bus.alu_x      = x_q;
    assign bus.alu_y      = y_q;
    assign bus.res_valid  = vld_q;
    assign bus.res_ans    = ans_q;
    assign bus.res_exceed = exc_q;
    assign bus.res_idx    = res_idx_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Self-checking bench for cmd_sequencer: two instances (STOP_ON_EXC 0/1)
// sharing one command ROM, each with its own behavioural ALU.
module tb_cmd_sequencer;
    import cmd_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [19:0] rom [16];

    logic        start_a [2];
    logic [3:0]  sa_a    [2];
    logic [4:0]  n_a     [2];
    logic        busy_a  [2];
    logic        done_a  [2];
    logic        vld_a   [2];
    logic        exc_a   [2];
    logic        cin_a   [2];
    logic [3:0]  addr_a  [2];
    logic [2:0]  s_a     [2];
    logic [7:0]  x_a     [2];
    logic [7:0]  y_a     [2];
    logic [15:0] ans_a   [2];
    logic [4:0]  idx_a   [2];

    // ALU model: cin only acts as the shift-in bit of SHL/SHR.
    function automatic logic [15:0] alu_f(logic [2:0] s, logic cin,
                                          logic [7:0] x, logic [7:0] y);
        case (s)
            3'd1:    return {8'h00, x & y};
            3'd2:    return {8'h00, x | y};
            3'd3:    return {8'h00, x ^ y};
            3'd4:    return {8'h00, x} + {8'h00, y};
            3'd5:    return {7'h00, x, cin};
            3'd6:    return {8'h00, cin, x[7:1]};
            3'd7:    return {8'h00, x[0], x[7:1]};
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic exc_f(logic [2:0] s, logic [15:0] ans);
        if (s == 3'd4) return ans > 16'h007F;
        if (s == 3'd5) return ans > 16'h00FF;
        return 1'b0;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g
        cmd_sequencer_if #(.ADDR_W(4)) bus();
        logic [19:0] rd_q  = '0;
        logic [15:0] aq    = '0;
        logic        eq    = 1'b0;

        always @(posedge clk) begin
            rd_q <= rom[bus.rom_addr];
            aq   <= alu_f(bus.alu_s, bus.alu_cin, bus.alu_x, bus.alu_y);
            eq   <= exc_f(bus.alu_s, aq);
        end

        assign bus.rom_data   = rd_q;
        assign bus.alu_ans    = aq;
        assign bus.alu_exceed = eq;

        cmd_sequencer #(.ADDR_W(4), .STOP_ON_EXC(k == 1)) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start_a[k]),
            .start_addr (sa_a[k]),
            .num_cmds   (n_a[k]),
            .bus        (bus),
            .busy       (busy_a[k]),
            .done       (done_a[k])
        );

        assign addr_a[k] = bus.rom_addr;
        assign s_a[k]    = bus.alu_s;
        assign x_a[k]    = bus.alu_x;
        assign y_a[k]    = bus.alu_y;
        assign cin_a[k]  = bus.alu_cin;
        assign vld_a[k]  = bus.res_valid;
        assign ans_a[k]  = bus.res_ans;
        assign exc_a[k]  = bus.res_exceed;
        assign idx_a[k]  = bus.res_idx;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs(int k);
        return {busy_a[k], done_a[k], addr_a[k], s_a[k], x_a[k], y_a[k],
                cin_a[k], vld_a[k], ans_a[k], exc_a[k], idx_a[k]};
    endfunction

    typedef struct {
        logic [3:0]  addr;
        logic [2:0]  s;
        logic [15:0] ans;
        logic        exc;
    } rec_t;

    // mode 1: extra start mid-run; mode 2: start in the done cycle.
    task automatic run(input int k, input int sa, input int n,
                       input int mode, output int got,
                       output logic [15:0] ans0, output logic exc0);
        rec_t       eq[$];
        rec_t       r;
        int         m;
        bit         seen;
        logic [3:0] ah [0:255];
        logic [2:0] sh [0:255];
        for (int i = 0; i < n; i++) begin
            logic [19:0] w;
            r.addr = 4'((sa + i) % 16);
            w      = rom[r.addr];
            r.s    = w[19:17];
            r.ans  = alu_f(w[19:17], w[16], w[15:8], w[7:0]);
            r.exc  = exc_f(r.s, r.ans);
            eq.push_back(r);
            if (k == 1 && r.exc) break;
        end
        m    = eq.size();
        got  = 0;
        ans0 = '0;
        exc0 = 1'b0;
        seen = 1'b0;
        @(negedge clk);
        start_a[k] = 1'b1;
        sa_a[k]    = 4'(sa);
        n_a[k]     = 5'(n);
        @(negedge clk);
        start_a[k] = 1'b0;
        chk("busy_after_start", busy_a[k], n != 0);
        for (int c = 1; c <= 5 * n + 10 && !seen; c++) begin
            if (c > 1) @(negedge clk);
            ah[c] = addr_a[k];
            sh[c] = s_a[k];
            if (mode == 1 && c == 3) begin
                start_a[k] = 1'b1;
                sa_a[k]    = 4'(sa + 7);
                n_a[k]     = 5'd9;
            end
            if (mode == 1 && c == 4) start_a[k] = 1'b0;
            if (vld_a[k]) begin
                if (got < m) begin
                    r = eq[got];
                    chk("res_cycle", c, 5 * got + 6);
                    chk("res_ans", ans_a[k], r.ans);
                    chk("res_exceed", exc_a[k], r.exc);
                    chk("res_idx", idx_a[k], got);
                    chk("rom_addr", ah[c-5], r.addr);
                    chk("alu_s_hold", {sh[c-3], sh[c-2], sh[c-1], sh[c]},
                        {4{r.s}});
                end else begin
                    chk("extra_record", got + 1, m);
                end
                if (got == 0) begin
                    ans0 = ans_a[k];
                    exc0 = exc_a[k];
                end
                got++;
            end
            if (done_a[k]) begin
                seen = 1'b1;
                chk("done_cycle", c, 5 * m + 1);
                chk("busy_at_done", busy_a[k], 0);
                chk("record_count", got, m);
                if (m > 0) chk("last_fetch", addr_a[k], (sa + m - 1) % 16);
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
        if (mode == 2) start_a[k] = 1'b1;
        @(negedge clk);
        start_a[k] = 1'b0;
        chk("done_one_cycle", done_a[k], 0);
        chk("idle_not_busy", busy_a[k], 0);
        chk("no_valid_after", vld_a[k], 0);
    endtask

    typedef struct {
        int          k;
        int          sa;
        int          n;
        int          mode;
        int          cnt;
        logic [15:0] ans0;
        logic        exc0;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int          got;
        logic [15:0] a0;
        logic        e0;
        int          q;

        tbl[0] = '{0, 0,  1, 0, 1, 16'h0030, 1'b0};
        tbl[1] = '{0, 2,  1, 0, 1, 16'h0080, 1'b1};
        tbl[2] = '{0, 14, 4, 0, 4, 16'h0033, 1'b0};
        tbl[3] = '{1, 4,  3, 0, 2, 16'h00F0, 1'b0};
        tbl[4] = '{0, 0,  0, 0, 0, 16'h0000, 1'b0};
        tbl[5] = '{0, 4,  3, 1, 3, 16'h00F0, 1'b0};
        tbl[6] = '{0, 0,  1, 2, 1, 16'h0030, 1'b0};

        for (int i = 0; i < 16; i++) rom[i] = '0;
        rom[0]  = {3'b001, 1'b0, 8'hF0, 8'h3C};
        rom[1]  = {3'b111, 1'b0, 8'h01, 8'h00};
        rom[2]  = {3'b100, 1'b1, 8'h7F, 8'h01};
        rom[4]  = {3'b011, 1'b0, 8'hFF, 8'h0F};
        rom[5]  = {3'b100, 1'b1, 8'h40, 8'h40};
        rom[6]  = {3'b001, 1'b0, 8'hAA, 8'h0F};
        rom[14] = {3'b010, 1'b0, 8'h12, 8'h21};
        rom[15] = {3'b101, 1'b1, 8'h81, 8'h00};
        for (int k = 0; k < 2; k++) begin
            start_a[k] = 1'b0;
            sa_a[k]    = '0;
            n_a[k]     = '0;
        end

        repeat (3) @(negedge clk);
        chk("reset_outputs_0", outs(0), 0);
        chk("reset_outputs_1", outs(1), 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            run(tbl[i].k, tbl[i].sa, tbl[i].n, tbl[i].mode, got, a0, e0);
            chk("tbl_count", got, tbl[i].cnt);
            chk("tbl_ans0", a0, tbl[i].ans0);
            chk("tbl_exc0", e0, tbl[i].exc0);
        end

        // Async reset while the first command sits in WAIT_ANS.
        @(negedge clk);
        start_a[0] = 1'b1;
        sa_a[0]    = 4'd0;
        n_a[0]     = 5'd3;
        @(negedge clk);
        start_a[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_midrun_outputs", outs(0), 0);
        q = 0;
        repeat (8) begin
            @(negedge clk);
            if (vld_a[0] || done_a[0]) q++;
        end
        chk("reset_quiet", q, 0);
        rst_n = 1'b1;
        run(0, 0, 1, 0, got, a0, e0);
        chk("after_reset_ans", a0, 16'h0030);

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 16; i++) rom[i] = 20'($urandom);
            run(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 20)), 0, got, a0, e0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
